// File: rtl/stream_id_demux.sv
// Packet demultiplexer: routes each input packet to the output channel named by
// the id on its head beat, with one output register per channel.
module stream_id_demux #(
    parameter int T_DATA_WIDTH = 4,
    parameter int M_DATA_COUNT = 2,
    localparam int ID_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [ID_WIDTH-1:0]     s_id_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o [M_DATA_COUNT],
    output logic [M_DATA_COUNT-1:0] m_last_o,
    output logic [M_DATA_COUNT-1:0] m_valid_o,
    input  logic [M_DATA_COUNT-1:0] m_ready_i,
    output logic                    err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [ID_WIDTH:0] CHAN_COUNT = (ID_WIDTH+1)'(M_DATA_COUNT);

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     lock_q, lock_d;
    logic [ID_WIDTH-1:0]     target;
    logic                    in_range;
    logic                    target_free;
    logic                    accept;
    logic [M_DATA_COUNT-1:0] load;

    // Out-of-range targets are always ready so their packets drain to nowhere.
    always_comb begin
        target      = (state_q == BUSY) ? lock_q : s_id_i;
        in_range    = ({1'b0, target} < CHAN_COUNT);
        target_free = 1'b0;
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            if (target == ID_WIDTH'(i)) begin
                target_free = !m_valid_o[i] || m_ready_i[i];
            end
        end
        s_ready_o = in_range ? target_free : 1'b1;
        accept    = s_valid_i && s_ready_o;
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            load[i] = accept && (target == ID_WIDTH'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (accept && !s_last_i) begin
                    state_d = BUSY;
                    lock_d  = s_id_i;
                end
            end
            BUSY: begin
                if (accept && s_last_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // A load wins over a drain, so a ready channel streams one beat per cycle.
    always_ff @(posedge clk) begin
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            if (rst) begin
                m_data_o[i]  <= '0;
                m_last_o[i]  <= 1'b0;
                m_valid_o[i] <= 1'b0;
            end else if (load[i]) begin
                m_data_o[i]  <= s_data_i;
                m_last_o[i]  <= s_last_i;
                m_valid_o[i] <= 1'b1;
            end else if (m_ready_i[i]) begin
                m_valid_o[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if (accept && !in_range) begin
            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_id_demux.sv
// Directed bench for stream_id_demux: a default two-channel instance plus a
// three-channel instance for the out-of-range id case.
module tb_stream_id_demux;

    typedef struct {
        int         ch;
        logic [3:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic [3:0] a_data;
    logic       a_id;
    logic       a_last;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] a_m_data [2];
    logic [1:0] a_m_last;
    logic [1:0] a_m_valid;
    logic [1:0] a_m_ready;
    logic       a_err;

    logic [3:0] b_data;
    logic [1:0] b_id;
    logic       b_last;
    logic       b_valid;
    logic       b_ready;
    logic [3:0] b_m_data [3];
    logic [2:0] b_m_last;
    logic [2:0] b_m_valid;
    logic [2:0] b_m_ready;
    logic       b_err;

    int    total = 0;
    int    bad   = 0;
    beat_t sb[$];

    always #5 clk = ~clk;

    stream_id_demux dut_a (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (a_data),
        .s_id_i    (a_id),
        .s_last_i  (a_last),
        .s_valid_i (a_valid),
        .s_ready_o (a_ready),
        .m_data_o  (a_m_data),
        .m_last_o  (a_m_last),
        .m_valid_o (a_m_valid),
        .m_ready_i (a_m_ready),
        .err_o     (a_err)
    );

    stream_id_demux #(.T_DATA_WIDTH(4), .M_DATA_COUNT(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (b_data),
        .s_id_i    (b_id),
        .s_last_i  (b_last),
        .s_valid_i (b_valid),
        .s_ready_o (b_ready),
        .m_data_o  (b_m_data),
        .m_last_o  (b_m_last),
        .m_valid_o (b_m_valid),
        .m_ready_i (b_m_ready),
        .err_o     (b_err)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Inputs change on the falling edge; a beat expected to be accepted is queued.
    task automatic apply_stimulus(input logic [3:0] data, input logic id, input logic last, input bit expect_accept);
        a_data  = data;
        a_id    = id;
        a_last  = last;
        a_valid = 1'b1;
        #1;
        check("s_ready", 32'(a_ready), 32'(expect_accept));
        if (expect_accept) sb.push_back('{ch: (a_valid_target(id)), data: data, last: last});
    endtask

    function automatic int a_valid_target(input logic id);
        return int'(id);
    endfunction

    task automatic push_beat(input int ch, input logic [3:0] data, input logic last);
        sb.push_back('{ch: ch, data: data, last: last});
    endtask

    task automatic check_output(input string tag);
        beat_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s observed=empty_scoreboard expected=beat", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(a_m_valid[e.ch]), 32'd1);
            check({tag, "_data"},  32'(a_m_data[e.ch]),  32'(e.data));
            check({tag, "_last"},  32'(a_m_last[e.ch]),  32'(e.last));
        end
    endtask

    initial begin
        rst = 1'b1;
        a_data = '0; a_id = '0; a_last = 1'b0; a_valid = 1'b0; a_m_ready = 2'b11;
        b_data = '0; b_id = '0; b_last = 1'b0; b_valid = 1'b0; b_m_ready = 3'b111;
        tick();
        tick();
        check("rst_valid", 32'(a_m_valid), 32'd0);
        check("rst_last",  32'(a_m_last),  32'd0);
        check("rst_data0", 32'(a_m_data[0]), 32'd0);
        check("rst_data1", 32'(a_m_data[1]), 32'd0);
        check("rst_err",   32'(a_err), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(a_ready), 32'd1);

        // Single-beat packet to channel 1.
        a_m_ready = 2'b11;
        apply_stimulus(4'hA, 1'b1, 1'b1, 1'b1);
        tick();
        a_valid = 1'b0;
        check("single_vmask", 32'(a_m_valid), 32'b10);
        check_output("single");
        tick();
        check("single_drained", 32'(a_m_valid), 32'b00);

        // Channel lock: id flips to 1 after the head, beats must stay on channel 0.
        apply_stimulus(4'h1, 1'b0, 1'b0, 1'b0 == 1'b0);
        tick();
        check("lock1_vmask", 32'(a_m_valid), 32'b01);
        check_output("lock1");
        a_data = 4'h2; a_id = 1'b1; a_last = 1'b0;
        #1 check("lock2_ready", 32'(a_ready), 32'd1);
        push_beat(0, 4'h2, 1'b0);
        tick();
        check("lock2_vmask", 32'(a_m_valid), 32'b01);
        check_output("lock2");
        a_data = 4'h3; a_id = 1'b1; a_last = 1'b1;
        #1 check("lock3_ready", 32'(a_ready), 32'd1);
        push_beat(0, 4'h3, 1'b1);
        tick();
        a_valid = 1'b0;
        check("lock3_vmask", 32'(a_m_valid), 32'b01);
        check_output("lock3");
        tick();
        check("lock_drained", 32'(a_m_valid), 32'b00);

        // Backpressure on channel 0.
        a_m_ready = 2'b10;
        apply_stimulus(4'h5, 1'b0, 1'b1, 1'b1);
        tick();
        check_output("bp_first");
        apply_stimulus(4'h6, 1'b0, 1'b1, 1'b0);
        tick();
        check("bp_hold_data",  32'(a_m_data[0]), 32'h5);
        check("bp_hold_valid", 32'(a_m_valid), 32'b01);
        #1 check("bp_still_blocked", 32'(a_ready), 32'd0);
        a_m_ready = 2'b11;
        #1 check("bp_release_ready", 32'(a_ready), 32'd1);
        push_beat(0, 4'h6, 1'b1);
        tick();
        a_valid = 1'b0;
        check_output("bp_second");
        tick();
        check("bp_drained", 32'(a_m_valid), 32'b00);

        // Channel 1 stalled full while a 3-beat packet streams into channel 0.
        a_m_ready = 2'b01;
        apply_stimulus(4'h7, 1'b1, 1'b1, 1'b1);
        tick();
        check_output("ind_ch1");
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(4'(8 + k), 1'b0, (k == 2), 1'b1);
            tick();
            check_output("ind_ch0");
            check("ind_ch1_valid", 32'(a_m_valid[1]), 32'd1);
            check("ind_ch1_data",  32'(a_m_data[1]),  32'h7);
        end
        a_valid = 1'b0;
        a_m_ready = 2'b11;
        tick();
        check("ind_drained", 32'(a_m_valid), 32'b00);

        // Reset in the middle of a packet locked to channel 1.
        a_m_ready = 2'b00;
        apply_stimulus(4'hB, 1'b1, 1'b0, 1'b1);
        tick();
        a_valid = 1'b0;
        check_output("mid_head");
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(a_m_valid), 32'b00);
        check("mid_rst_err",   32'(a_err), 32'd0);
        rst = 1'b0;
        a_m_ready = 2'b11;
        apply_stimulus(4'hC, 1'b0, 1'b1, 1'b1);
        tick();
        a_valid = 1'b0;
        check("mid_new_vmask", 32'(a_m_valid), 32'b01);
        check_output("mid_new");
        check("a_err_clear", 32'(a_err), 32'd0);

        // Three-channel instance: id 3 is out of range and must be swallowed.
        b_data = 4'h1; b_id = 2'd3; b_last = 1'b0; b_valid = 1'b1;
        #1 check("oor1_ready", 32'(b_ready), 32'd1);
        tick();
        check("oor1_vmask", 32'(b_m_valid), 32'b000);
        check("oor1_err",   32'(b_err), 32'd1);
        b_data = 4'h2; b_id = 2'd0; b_last = 1'b1;
        #1 check("oor2_ready", 32'(b_ready), 32'd1);
        tick();
        check("oor2_vmask", 32'(b_m_valid), 32'b000);
        check("oor2_err",   32'(b_err), 32'd1);
        b_data = 4'h4; b_id = 2'd2; b_last = 1'b1;
        tick();
        b_valid = 1'b0;
        check("oor_next_vmask", 32'(b_m_valid), 32'b100);
        check("oor_next_data",  32'(b_m_data[2]), 32'h4);
        check("oor_err_sticky", 32'(b_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("oor_err_rst", 32'(b_err), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_id_demux.md
STREAM_ID_DEMUX -- requirements
Module: stream_id_demux

Interface
REQ-001 The module SHALL have parameter T_DATA_WIDTH, default 4, meaning the data beat width in bits.
REQ-002 The module SHALL have parameter M_DATA_COUNT, default 2, meaning the number of output channels (minimum 2).
REQ-003 The module SHALL have localparam ID_WIDTH = $clog2(M_DATA_COUNT), meaning the id field width.
REQ-004 The module SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 The module SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The module SHALL have port s_data_i  input  T_DATA_WIDTH  input beat data.
REQ-007 The module SHALL have port s_id_i  input  ID_WIDTH  target channel; sampled on packet head beat only.
REQ-008 The module SHALL have port s_last_i  input  1  last beat of packet.
REQ-009 The module SHALL have port s_valid_i  input  1  input beat valid.
REQ-010 The module SHALL have port s_ready_o  output  1  input beat accepted when s_valid_i && s_ready_o.
REQ-011 The module SHALL have port m_data_o  output  unpacked [M_DATA_COUNT] x T_DATA_WIDTH  per-channel data.
REQ-012 The module SHALL have port m_last_o  output  M_DATA_COUNT  per-channel last.
REQ-013 The module SHALL have port m_valid_o  output  M_DATA_COUNT  per-channel valid.
REQ-014 The module SHALL have port m_ready_i  input  M_DATA_COUNT  per-channel ready.
REQ-015 The module SHALL have port err_o  output  1  sticky error: beat with out-of-range id was received.

Function
REQ-016 The module SHALL route each input packet, unmodified, to channel s_id_i as sampled on the head beat of that packet.
REQ-017 The module SHALL implement FSM states IDLE (no packet open) and BUSY (packet open, locked channel register lock_q).
REQ-018 In IDLE, the target SHALL be s_id_i; in BUSY, the target SHALL be lock_q and s_id_i SHALL be ignored.
REQ-019 On IDLE, acceptance of a beat with s_last_i=0 SHALL load lock_q from s_id_i and move to BUSY.
REQ-020 On IDLE, acceptance of a beat with s_last_i=1 SHALL leave the FSM in IDLE (single-beat packet).
REQ-021 In BUSY, acceptance of a beat with s_last_i=1 SHALL move the FSM to IDLE; other accepted beats SHALL keep BUSY.
REQ-022 Each channel SHALL have one output register (data, last, valid); latency input-accept to m_valid_o SHALL be exactly 1 cycle.
REQ-023 s_ready_o SHALL equal !m_valid_o[target] || m_ready_i[target] for in-range target, giving full throughput (1 beat/cycle) into a ready channel.
REQ-024 A channel register SHALL load on input accept for that target; it SHALL clear valid when m_ready_i && m_valid_o and there is no new load in the same cycle.
REQ-025 Simultaneous drain and load on one channel SHALL replace the register contents with the new beat, with valid remaining 1.
REQ-026 Output registers of non-target channels SHALL hold while m_ready_i=0 and drain independently.
REQ-027 m_data_o and m_last_o SHALL be stable while m_valid_o=1 and m_ready_i=0.
REQ-028 If the target id >= M_DATA_COUNT, s_ready_o SHALL be 1 and the beats SHALL be accepted and discarded through the packet last beat.
REQ-029 err_o SHALL be set on the cycle after accept of an out-of-range beat; it SHALL stay set until rst.
REQ-030 s_ready_o SHALL NOT depend on s_valid_i.

Reset
REQ-031 While rst=1 at a clock edge, the FSM SHALL enter IDLE and lock_q SHALL be 0.
REQ-032 While rst=1 at a clock edge, all m_valid_o, m_last_o, m_data_o and err_o SHALL be 0.
REQ-033 Reset mid-packet SHALL discard the open packet and buffered beats, and the next accepted beat SHALL be treated as a head.
REQ-034 On the cycle after rst deasserts, s_ready_o SHALL be 1.

Verification
REQ-035 Single-beat packet (defaults): data=0xA, id=1, last=1, valid=1, m_ready=11 -> next cycle m_valid_o=10, m_data_o[1]=0xA, m_last_o[1]=1; the cycle after that, m_valid_o=00.
REQ-036 Lock test: 3-beat packet 0x1,0x2,0x3 with head id=0 and s_id_i toggled to 1 on beats 2-3 -> all three beats appear on channel 0 on consecutive cycles, last on 0x3, and channel 1 never valid.
REQ-037 Backpressure: m_ready_i[0]=0 with a beat held in channel 0 and a second beat to channel 0 -> s_ready_o=0 and m_data_o[0] stable; raise m_ready_i[0] -> second beat accepted the same cycle and output the next cycle.
REQ-038 Independence: channel 1 stalled full, packet to channel 0 -> accepted at 1 beat/cycle, and channel 1 contents unchanged.
REQ-039 M_DATA_COUNT=3, head id=3, 2-beat packet -> s_ready_o=1 for both beats, no m_valid_o, err_o=1 from the cycle after beat 1 until rst.
REQ-040 rst=1 asserted mid-packet (BUSY, lock=1) -> all m_valid_o=0 and err_o=0; next beat with id=0, last=1 goes to channel 0.
